// File: rtl/switch_debouncer_pkg.sv
// Shared constants and FSM state type for the switch debouncer.
package switch_debouncer_pkg;

   localparam int unsigned CLK_HZ                  = 50_000_000;
   localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = CLK_HZ / 100;  // 10 ms
   localparam int unsigned DEFAULT_CNT_W           = 19;

   typedef enum logic {
      ST_STABLE    = 1'b0,
      ST_COUNTING  = 1'b1
   } db_state_t;

endpackage

// File: rtl/switch_debouncer_bit.sv
// Single-bit debouncer: two-flop synchronizer, STABLE/COUNTING FSM, stability counter.
module debounce_bit
   import switch_debouncer_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int unsigned CNT_W           = DEFAULT_CNT_W
) (
   input  logic clk,
   input  logic reset,
   input  logic i_raw,
   output logic o_level,
   output logic o_update
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [1:0]       r_sync;
   db_state_t        r_state, w_state_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic             r_level, w_level_nxt;
   logic             r_upd, w_upd_nxt;
   logic             w_differs;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_sync <= '0;
      else       r_sync <= {r_sync[0], i_raw};
   end

   assign w_differs = r_sync[1] ^ r_level;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_STABLE;
         r_cnt   <= '0;
         r_level <= 1'b0;
         r_upd   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_level <= w_level_nxt;
         r_upd   <= w_upd_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_level_nxt = r_level;
      w_upd_nxt   = 1'b0;
      case (r_state)
         ST_STABLE: begin
            if (w_differs) begin
               // A one-cycle window is already satisfied by the first differing sample.
               if (DEBOUNCE_CYCLES == 1) begin
                  w_level_nxt = r_sync[1];
                  w_upd_nxt   = 1'b1;
               end else begin
                  w_state_nxt = ST_COUNTING;
                  w_cnt_nxt   = CNT_W'(1);
               end
            end
         end
         ST_COUNTING: begin
            if (!w_differs) begin
               w_state_nxt = ST_STABLE;
               w_cnt_nxt   = '0;
            end else if (r_cnt == LAST) begin
               w_state_nxt = ST_STABLE;
               w_cnt_nxt   = '0;
               w_level_nxt = r_sync[1];
               w_upd_nxt   = 1'b1;
            end else begin
               w_cnt_nxt   = r_cnt + CNT_W'(1);
            end
         end
      endcase
   end

   assign o_level  = r_level;
   assign o_update = r_upd;

endmodule

// File: rtl/switch_debouncer.sv
// Parallel switch debouncer: WIDTH independent debounce_bit instances plus a shared change strobe.
module switch_debouncer
   import switch_debouncer_pkg::*;
#(
   parameter int unsigned WIDTH           = 4,
   parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int unsigned CNT_W           = DEFAULT_CNT_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] switches_raw,
   output logic [WIDTH-1:0] switches,
   output logic             changed,
   output logic [WIDTH-1:0] changed_mask
);

   for (genvar g = 0; g < WIDTH; g++) begin : g_bit
      debounce_bit #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .CNT_W           (CNT_W)
      ) u_bit (
         .clk      (clk),
         .reset    (reset),
         .i_raw    (switches_raw[g]),
         .o_level  (switches[g]),
         .o_update (changed_mask[g])
      );
   end

   assign changed = |changed_mask;

endmodule

// File: tb/tb_switch_debouncer.sv
// Self-checking bench: sliding-window reference model feeds a scoreboard queue checked each clock.
module tb_switch_debouncer;

   localparam int W = 4;
   localparam int D = 4;

   typedef struct packed {
      logic [W-1:0] sw;
      logic         chg;
      logic [W-1:0] mask;
   } exp_t;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic [W-1:0] switches_raw = '0;
   logic [W-1:0] switches;
   logic         changed;
   logic [W-1:0] changed_mask;

   int checks = 0;
   int errors = 0;

   exp_t         sb[$];
   logic [W-1:0] hist[$];
   logic [W-1:0] m_sw = '0;
   int           edge_no;
   int           strobes;
   int           strobe_edge;
   logic [W-1:0] strobe_mask;

   always #5 clk = ~clk;

   switch_debouncer #(
      .WIDTH           (W),
      .DEBOUNCE_CYCLES (D),
      .CNT_W           (3)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .switches_raw (switches_raw),
      .switches     (switches),
      .changed      (changed),
      .changed_mask (changed_mask)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Level flips when the D samples that reached the FSM (edges k-D-1..k-2) all differ from it.
   function automatic void model_edge();
      exp_t         e;
      logic [W-1:0] mask;
      logic [W-1:0] cur;
      bit           all_diff;
      if (reset) begin
         m_sw = '0;
         hist.delete();
         for (int i = 0; i < D + 2; i++) hist.push_back('0);
         e = '{sw: '0, chg: 1'b0, mask: '0};
         sb.push_back(e);
         return;
      end
      hist.push_back(switches_raw);
      if (hist.size() > D + 2) void'(hist.pop_front());
      mask = '0;
      for (int b = 0; b < W; b++) begin
         all_diff = 1'b1;
         for (int i = 0; i < D; i++) begin
            cur = hist[i];
            if (cur[b] == m_sw[b]) all_diff = 1'b0;
         end
         mask[b] = all_diff;
      end
      m_sw = m_sw ^ mask;
      e = '{sw: m_sw, chg: |mask, mask: mask};
      sb.push_back(e);
   endfunction

   task automatic step();
      exp_t e;
      @(posedge clk);
      model_edge();
      edge_no++;
      #1;
      if (sb.size() == 0) begin
         check("sb_empty", 32'd1, 32'd0);
      end else begin
         e = sb.pop_front();
         check("switches", 32'(switches), 32'(e.sw));
         check("changed", 32'(changed), 32'(e.chg));
         check("changed_mask", 32'(changed_mask), 32'(e.mask));
      end
      if (changed) begin
         strobes++;
         strobe_edge = edge_no;
         strobe_mask = changed_mask;
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic begin_scn();
      edge_no     = 0;
      strobes     = 0;
      strobe_edge = 0;
      strobe_mask = '0;
   endtask

   initial begin
      reset        = 1'b1;
      switches_raw = '0;
      run(2);
      reset = 1'b0;
      run(3);

      // steady raise
      switches_raw = 4'b0001;
      begin_scn();
      run(10);
      check("raise_strobes", 32'(strobes), 32'd1);
      check("raise_edge", 32'(strobe_edge), 32'd6);
      check("raise_mask", 32'(strobe_mask), 32'h1);

      // bounce rejection
      switches_raw = 4'b0000;
      run(10);
      begin_scn();
      switches_raw = 4'b0001; step();
      switches_raw = 4'b0000; step();
      switches_raw = 4'b0001; step();
      switches_raw = 4'b0000; step();
      check("bounce_nostrobe", 32'(strobes), 32'd0);
      switches_raw = 4'b0001;
      begin_scn();
      run(10);
      check("bounce_strobes", 32'(strobes), 32'd1);
      check("bounce_edge", 32'(strobe_edge), 32'd6);

      // short glitch on bit2
      switches_raw = 4'b0101;
      begin_scn();
      run(3);
      switches_raw = 4'b0001;
      run(10);
      check("glitch_strobes", 32'(strobes), 32'd0);
      check("glitch_sw", 32'(switches), 32'h1);

      // simultaneous rise of bits 1 and 3
      switches_raw = 4'b0000;
      run(10);
      switches_raw = 4'b1010;
      begin_scn();
      run(10);
      check("sim_strobes", 32'(strobes), 32'd1);
      check("sim_mask", 32'(strobe_mask), 32'ha);
      check("sim_edge", 32'(strobe_edge), 32'd6);
      check("sim_sw", 32'(switches), 32'ha);

      // reset mid-count
      switches_raw = 4'b0000;
      run(10);
      switches_raw = 4'b0001;
      begin_scn();
      run(3);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("rstmid_strobes", 32'(strobes), 32'd0);
      begin_scn();
      run(10);
      check("rstmid_edge", 32'(strobe_edge), 32'd6);
      check("rstmid_mask", 32'(strobe_mask), 32'h1);

      // release from 1111
      switches_raw = 4'b1111;
      run(10);
      check("all_high", 32'(switches), 32'hf);
      switches_raw = 4'b0000;
      begin_scn();
      run(10);
      check("release_edge", 32'(strobe_edge), 32'd6);
      check("release_mask", 32'(strobe_mask), 32'hf);

      // asynchronous reset with switches high, then recovery with raw held high
      switches_raw = 4'b1111;
      run(10);
      #2;
      reset = 1'b1;
      #1;
      check("async_sw", 32'(switches), 32'h0);
      check("async_chg", 32'(changed), 32'h0);
      check("async_mask", 32'(changed_mask), 32'h0);
      step();
      reset = 1'b0;
      begin_scn();
      run(10);
      check("post_rst_edge", 32'(strobe_edge), 32'd6);
      check("post_rst_mask", 32'(strobe_mask), 32'hf);
      check("post_rst_strobes", 32'(strobes), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
